qpp_addr_gen: RTL

Turbo-interleaver address generator sitting directly downstream of the sequential index counter. It consumes the index stream i = 0..K−1 and produces the LTE QPP interleaved address π(i) = (f1·i + f2·i²) mod K, one address per new index. Its output drives the interleaver memory read address. Two block sizes are supported: K=1056 (f1=17, f2=66) and K=6144 (f1=263, f2=480).

---
 rtl/qpp_addr_gen.sv | 85 ++++++++
 1 files changed

// File: rtl/qpp_addr_gen.sv
// qpp_addr_gen: recursive LTE QPP interleaver address generator (K=1056/6144); optional QPP_SEQ_CHECK_EN enables sequence-error detection
module qpp_addr_gen (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_k,
  input  logic        i_in_valid,
  input  logic [13:0] i_in_idx,
  output logic        o_out_valid,
  output logic [12:0] o_out_addr,
  output logic [13:0] o_out_idx,
  output logic        o_done,
  output logic        o_seq_err
);
  logic        r_k_lat, r_active, r_done, r_seq_err, r_out_valid;
  logic [13:0] r_last_idx, r_out_idx;
  logic [12:0] r_pi, r_g, r_out_addr;
  logic [13:0] w_kmod;
  logic [12:0] w_step, w_pi_nx, w_g_nx;
  logic        w_zero, w_rep, w_adv, w_err;

  function automatic logic [12:0] mod_add(input logic [12:0] a, input logic [12:0] b, input logic [13:0] m);
    logic [13:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= m) ? 13'(s - m) : s[12:0];
  endfunction

  // accept decode and one-step recursion of pi and g
  always_comb begin
    w_kmod  = r_k_lat ? 14'd6144 : 14'd1056;
    w_step  = r_k_lat ? 13'd960 : 13'd132;
    w_pi_nx = mod_add(r_pi, r_g, w_kmod);
    w_g_nx  = mod_add(r_g, w_step, w_kmod);
    w_zero  = i_in_valid && (i_in_idx == 14'd0);
    w_rep   = r_active && (i_in_idx == r_last_idx);
`ifdef QPP_SEQ_CHECK_EN
    w_adv   = i_in_valid && r_active && (i_in_idx == r_last_idx + 14'd1) && (r_last_idx < w_kmod - 14'd1);
    w_err   = i_in_valid && !w_zero && !w_rep && !w_adv;
`else
    w_adv   = i_in_valid && r_active && !r_done && (i_in_idx != 14'd0) && !w_rep;
    w_err   = 1'b0;
`endif
  end

  // block state and registered outputs; index 0 always restarts the block
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_k_lat     <= 1'b0;
      r_active    <= 1'b0;
      r_done      <= 1'b0;
      r_seq_err   <= 1'b0;
      r_out_valid <= 1'b0;
      r_last_idx  <= '0;
      r_out_idx   <= '0;
      r_out_addr  <= '0;
      r_pi        <= '0;
      r_g         <= '0;
    end else begin
      r_out_valid <= w_zero || w_adv;
      if (w_zero) begin
        r_k_lat    <= i_k;
        r_active   <= 1'b1;
        r_done     <= 1'b0;
        r_pi       <= '0;
        r_g        <= i_k ? 13'd743 : 13'd83;
        r_last_idx <= '0;
        r_out_addr <= '0;
        r_out_idx  <= '0;
      end else if (w_adv) begin
        r_pi       <= w_pi_nx;
        r_g        <= w_g_nx;
        r_last_idx <= i_in_idx;
        r_out_addr <= w_pi_nx;
        r_out_idx  <= i_in_idx;
        r_done     <= i_in_idx >= w_kmod - 14'd1;
      end
      if (w_err) r_seq_err <= 1'b1;
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_addr  = r_out_addr;
  assign o_out_idx   = r_out_idx;
  assign o_done      = r_done;
  assign o_seq_err   = r_seq_err;
endmodule
